// File: rtl/packet_receiver.sv
// NOC packet link receive end: address filter, small FIFO and burst-length tracking.
// Optional PKT_RX_STATS_EN adds saturating rx_count/drop_count statistics outputs.
module packet_receiver #(
    parameter int WIDTH_TYPE    = 2,
    parameter int WIDTH_PAYLOAD = 8,
    parameter int WIDTH_PACKET  = 13,
    parameter int FIFO_DEPTH    = 4,
    parameter int MY_ADDR       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH_PACKET-1:0]  packet,
    input  logic                     valid,
    input  logic                     last,
    output logic                     ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH_TYPE-1:0]    out_dest,
    output logic [WIDTH_TYPE-1:0]    out_type,
    output logic [WIDTH_PAYLOAD-1:0] out_payload,
    output logic                     out_eop,
    output logic                     out_last,
    output logic                     drop_err,
    output logic                     burst_done,
    output logic [7:0]               burst_len
`ifdef PKT_RX_STATS_EN
    ,
    output logic [15:0]              rx_count,
    output logic [15:0]              drop_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, IN_BURST} state_t;

    logic [WIDTH_PACKET:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [WIDTH_PACKET:0] head;
    logic                  full, accept, addr_hit, push, pop;

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next, cnt_inc, len_next;
    logic       done_next;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign ready     = !full;
    assign accept    = valid && ready;
    assign addr_hit  = (packet[WIDTH_TYPE-1:0] == WIDTH_TYPE'(MY_ADDR));
    assign push      = accept && addr_hit;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // Head fields are forced to zero while empty so stale entries never leak out.
    assign head        = out_valid ? mem[rd_ptr] : '0;
    assign out_dest    = head[WIDTH_TYPE-1:0];
    assign out_type    = head[2*WIDTH_TYPE-1:WIDTH_TYPE];
    assign out_payload = head[2*WIDTH_TYPE+WIDTH_PAYLOAD-1:2*WIDTH_TYPE];
    assign out_eop     = head[WIDTH_PACKET-1];
    assign out_last    = head[WIDTH_PACKET];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {last, packet};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            drop_err <= accept && !addr_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            burst_done <= 1'b0;
            burst_len  <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            burst_done <= done_next;
            burst_len  <= len_next;
        end
    end

    assign cnt_inc = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;

    // Every accepted beat counts, including those later dropped by the address filter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        len_next   = burst_len;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (last) begin
                        done_next = 1'b1;
                        len_next  = 8'd1;
                    end else begin
                        state_next = IN_BURST;
                        cnt_next   = 8'd1;
                    end
                end
            end
            IN_BURST: begin
                if (accept) begin
                    if (last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        len_next   = cnt_inc;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PKT_RX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (push && rx_count != 16'hFFFF)
                rx_count <= rx_count + 16'd1;
            if (accept && !addr_hit && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_packet_receiver.sv
// Directed testbench for packet_receiver with a queue-based reference model checked every cycle.
module tb_packet_receiver;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] packet = '0;
    logic        valid = 1'b0, last = 1'b0, out_ready = 1'b0;
    logic        ready, out_valid, out_eop, out_last, drop_err, burst_done;
    logic [1:0]  out_dest, out_type;
    logic [7:0]  out_payload, burst_len;
`ifdef PKT_RX_STATS_EN
    logic [15:0] rx_count, drop_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    packet_receiver dut (
        .clk(clk), .rst(rst), .packet(packet), .valid(valid), .last(last),
        .ready(ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_dest(out_dest), .out_type(out_type), .out_payload(out_payload),
        .out_eop(out_eop), .out_last(out_last), .drop_err(drop_err),
        .burst_done(burst_done), .burst_len(burst_len)
`ifdef PKT_RX_STATS_EN
        , .rx_count(rx_count), .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of {last, packet} plus beat counting per burst.
    logic [13:0] mq[$];
    int          m_beats = 0;
    bit          m_drop = 0, m_done = 0, m_acc, m_hit;
    logic [7:0]  m_len = '0;
    int          m_rx = 0, m_dc = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_beats = 0; m_drop = 0; m_done = 0; m_len = '0; m_rx = 0; m_dc = 0;
        end else begin
            m_acc  = valid && (mq.size() < DEPTH);
            m_hit  = m_acc && (packet[1:0] == 2'd0);
            m_drop = m_acc && !m_hit;
            m_done = 0;
            if (mq.size() > 0 && out_ready)
                void'(mq.pop_front());
            if (m_hit) begin
                mq.push_back({last, packet});
                if (m_rx < 65535) m_rx++;
            end
            if (m_drop && m_dc < 65535) m_dc++;
            if (m_acc) begin
                m_beats++;
                if (last) begin
                    m_done  = 1;
                    m_len   = (m_beats > 255) ? 8'd255 : 8'(m_beats);
                    m_beats = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [12:0] p, input logic v, input logic l, input logic r);
        @(posedge clk);
        #1;
        packet = p; valid = v; last = l; out_ready = r;
    endtask

    function automatic logic [12:0] mk(input logic [7:0] pl, input logic [1:0] ty, input logic [1:0] de, input logic eop);
        return {eop, pl, ty, de};
    endfunction

    logic [13:0] h;
    always @(negedge clk) begin
        h = (mq.size() > 0) ? mq[0] : 14'h0;
        checkOutput("ready",       ready,       mq.size() < DEPTH);
        checkOutput("out_valid",   out_valid,   mq.size() != 0);
        checkOutput("out_dest",    out_dest,    h[1:0]);
        checkOutput("out_type",    out_type,    h[3:2]);
        checkOutput("out_payload", out_payload, h[11:4]);
        checkOutput("out_eop",     out_eop,     h[12]);
        checkOutput("out_last",    out_last,    h[13]);
        checkOutput("drop_err",    drop_err,    m_drop);
        checkOutput("burst_done",  burst_done,  m_done);
        checkOutput("burst_len",   burst_len,   m_len);
`ifdef PKT_RX_STATS_EN
        checkOutput("rx_count",    rx_count,    m_rx);
        checkOutput("drop_count",  drop_count,  m_dc);
`endif
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset release, idle inputs
        @(negedge clk);
        checkOutput("t1_ready", ready, 1);
        checkOutput("t1_out_valid", out_valid, 0);
        checkOutput("t1_drop_err", drop_err, 0);
        checkOutput("t1_burst_done", burst_done, 0);

        // Single well-addressed one-beat burst
        applyStimulus(13'h1A50, 1, 1, 1);
        applyStimulus(13'h0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t2_out_valid", out_valid, 1);
        checkOutput("t2_payload", out_payload, 8'hA5);
        checkOutput("t2_type", out_type, 0);
        checkOutput("t2_eop", out_eop, 1);
        checkOutput("t2_burst_done", burst_done, 1);
        checkOutput("t2_burst_len", burst_len, 1);

        // Misaddressed one-beat burst
        applyStimulus(13'h0336, 1, 1, 1);
        applyStimulus(13'h0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t3_out_valid", out_valid, 0);
        checkOutput("t3_drop_err", drop_err, 1);
        checkOutput("t3_burst_done", burst_done, 1);
        checkOutput("t3_burst_len", burst_len, 1);

        // Fill FIFO with consumer stalled; fifth beat waits for a pop
        for (int i = 0; i < 4; i++)
            applyStimulus(mk(8'h10 + 8'(i), 2'(i), 2'd0, 1'b0), 1, 0, 0);
        applyStimulus(mk(8'h14, 2'd1, 2'd0, 1'b1), 1, 1, 0);
        @(negedge clk);
        checkOutput("t4_ready_full", ready, 0);
        checkOutput("t4_head_payload", out_payload, 8'h10);
        applyStimulus(mk(8'h14, 2'd1, 2'd0, 1'b1), 1, 1, 0);
        applyStimulus(mk(8'h14, 2'd1, 2'd0, 1'b1), 1, 1, 1);
        applyStimulus(mk(8'h14, 2'd1, 2'd0, 1'b1), 1, 1, 1);
        applyStimulus(13'h0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t4_burst_done", burst_done, 1);
        checkOutput("t4_burst_len", burst_len, 5);
        checkOutput("t4_head_payload2", out_payload, 8'h12);
        repeat (6) applyStimulus(13'h0, 0, 0, 1);

        // Three-beat burst with a misaddressed middle beat
        applyStimulus(mk(8'h51, 2'd1, 2'd0, 1'b0), 1, 0, 1);
        applyStimulus(mk(8'h52, 2'd2, 2'd1, 1'b0), 1, 0, 1);
        applyStimulus(mk(8'h53, 2'd3, 2'd0, 1'b1), 1, 1, 1);
        @(negedge clk);
        checkOutput("t5_drop_err", drop_err, 1);
        applyStimulus(13'h0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t5_burst_done", burst_done, 1);
        checkOutput("t5_burst_len", burst_len, 3);
        checkOutput("t5_payload", out_payload, 8'h53);
        repeat (3) applyStimulus(13'h0, 0, 0, 1);

        // Reset in the middle of a burst with two entries buffered
        applyStimulus(mk(8'h61, 2'd0, 2'd0, 1'b0), 1, 0, 0);
        applyStimulus(mk(8'h62, 2'd0, 2'd0, 1'b0), 1, 0, 0);
        applyStimulus(13'h0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t6_out_valid_pre", out_valid, 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("t6_out_valid_rst", out_valid, 0);
        checkOutput("t6_ready_rst", ready, 1);
`ifdef PKT_RX_STATS_EN
        checkOutput("t6_rx_count", rx_count, 0);
        checkOutput("t6_drop_count", drop_count, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(mk(8'h70, 2'd0, 2'd0, 1'b1), 1, 1, 1);
        applyStimulus(13'h0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t6_burst_done", burst_done, 1);
        checkOutput("t6_burst_len", burst_len, 1);
        checkOutput("t6_payload", out_payload, 8'h70);
        repeat (3) applyStimulus(13'h0, 0, 0, 1);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
